// File: rtl/cbus_slv_resp_if.sv
// cbus request/response signal bundle between a bus master and a responder.
// The master drives the request level and attributes; the responder returns pulses.
interface cbus_slv_resp_if #(
   parameter int unsigned AW = 16
) ();

   logic          cbus_m_req;
   logic          cbus_m_wr;
   logic [AW-1:0] cbus_m_addr;
   logic [31:0]   cbus_m_wdata;
   logic          cbus_s_waccept;
   logic          cbus_s_rresp;
   logic [31:0]   cbus_s_rdata;
   logic          cbus_s_err;

   modport master (
      output cbus_m_req,
      output cbus_m_wr,
      output cbus_m_addr,
      output cbus_m_wdata,
      input  cbus_s_waccept,
      input  cbus_s_rresp,
      input  cbus_s_rdata,
      input  cbus_s_err
   );

   modport slave (
      input  cbus_m_req,
      input  cbus_m_wr,
      input  cbus_m_addr,
      input  cbus_m_wdata,
      output cbus_s_waccept,
      output cbus_s_rresp,
      output cbus_s_rdata,
      output cbus_s_err
   );

endinterface

// File: rtl/cbus_slv_resp.sv
// cbus responder: forwards one master request at a time to a local register port,
// returns a single-cycle waccept/rresp pulse, tracks master aborts and local timeouts.
module cbus_slv_resp #(
   parameter int unsigned AW       = 16,
   parameter logic [15:0] LOCAL_TO = 16'd64,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic          cbus_clk,
   input  logic          cbus_rst_n,
   cbus_slv_resp_if.slave cbus,
   output logic          reg_req,
   output logic          reg_wr,
   output logic [AW-1:0] reg_addr,
   output logic [31:0]   reg_wdata,
   input  logic          reg_ack,
   input  logic [31:0]   reg_rdata,
   output logic [15:0]   abort_cnt
);

   typedef enum logic [1:0] {StIdle, StWait, StResp, StDrain} state_e;

   state_e        state_q, state_d;
   logic          reg_req_q, reg_req_d;
   logic          reg_wr_q, reg_wr_d;
   logic [AW-1:0] reg_addr_q, reg_addr_d;
   logic [31:0]   reg_wdata_q, reg_wdata_d;
   logic [15:0]   to_cnt_q, to_cnt_d;
   logic          abort_q, abort_d;
   logic [15:0]   abort_cnt_q, abort_cnt_d;
   logic          waccept_q, waccept_d;
   logic          rresp_q, rresp_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          abort_now;
   logic          timeout;

   // Abort also covers the master dropping its request in the last WAIT cycle.
   assign abort_now = abort_q | ~cbus.cbus_m_req;
   assign timeout   = (LOCAL_TO != 16'd0) && (to_cnt_q == LOCAL_TO - 16'd1);

   always_ff @(posedge cbus_clk or negedge cbus_rst_n) begin
      if (!cbus_rst_n) begin
         state_q     <= StIdle;
         reg_req_q   <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         to_cnt_q    <= '0;
         abort_q     <= 1'b0;
         abort_cnt_q <= '0;
         waccept_q   <= 1'b0;
         rresp_q     <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_req_q   <= reg_req_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         to_cnt_q    <= to_cnt_d;
         abort_q     <= abort_d;
         abort_cnt_q <= abort_cnt_d;
         waccept_q   <= waccept_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      reg_req_d   = reg_req_q;
      reg_wr_d    = reg_wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      to_cnt_d    = to_cnt_q;
      abort_d     = abort_q;
      abort_cnt_d = abort_cnt_q;
      waccept_d   = 1'b0;
      rresp_d     = 1'b0;
      rdata_d     = '0;
      err_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cbus.cbus_m_req) begin
               reg_wr_d    = cbus.cbus_m_wr;
               reg_addr_d  = cbus.cbus_m_addr;
               reg_wdata_d = cbus.cbus_m_wdata;
               reg_req_d   = 1'b1;
               to_cnt_d    = '0;
               abort_d     = 1'b0;
               state_d     = StWait;
            end
         end
         StWait: begin
            abort_d = abort_now;
            // reg_ack takes priority over a coincident timeout.
            if (reg_ack || timeout) begin
               reg_req_d = 1'b0;
               state_d   = StResp;
               if (!abort_now) begin
                  err_d = ~reg_ack;
                  if (reg_wr_q) begin
                     waccept_d = 1'b1;
                  end else begin
                     rresp_d = 1'b1;
                     rdata_d = reg_ack ? reg_rdata : ERR_DATA;
                  end
               end
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         StResp: begin
            if (abort_q) begin
               if (abort_cnt_q != 16'hFFFF) begin
                  abort_cnt_d = abort_cnt_q + 16'd1;
               end
               state_d = StIdle;
            end else begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!cbus.cbus_m_req) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign reg_req             = reg_req_q;
   assign reg_wr              = reg_wr_q;
   assign reg_addr            = reg_addr_q;
   assign reg_wdata           = reg_wdata_q;
   assign abort_cnt           = abort_cnt_q;
   assign cbus.cbus_s_waccept = waccept_q;
   assign cbus.cbus_s_rresp   = rresp_q;
   assign cbus.cbus_s_rdata   = rdata_q;
   assign cbus.cbus_s_err     = err_q;

endmodule

// File: tb/tb_cbus_slv_resp.sv
// Directed bench for cbus_slv_resp: expected responses are queued when a request is
// issued and checked by a monitor when the responder pulses.
module tb_cbus_slv_resp;

   localparam int unsigned AW       = 16;
   localparam logic [15:0] LOCAL_TO = 16'd8;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   logic          cbus_clk = 1'b0;
   logic          cbus_rst_n = 1'b0;
   logic          reg_req;
   logic          reg_wr;
   logic [AW-1:0] reg_addr;
   logic [31:0]   reg_wdata;
   logic          reg_ack;
   logic [31:0]   reg_rdata;
   logic [15:0]   abort_cnt;

   always #5 cbus_clk = ~cbus_clk;

   cbus_slv_resp_if #(.AW(AW)) cbus ();

   cbus_slv_resp #(
      .AW       (AW),
      .LOCAL_TO (LOCAL_TO),
      .ERR_DATA (ERR_DATA)
   ) dut (
      .cbus_clk   (cbus_clk),
      .cbus_rst_n (cbus_rst_n),
      .cbus       (cbus.slave),
      .reg_req    (reg_req),
      .reg_wr     (reg_wr),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_ack    (reg_ack),
      .reg_rdata  (reg_rdata),
      .abort_cnt  (abort_cnt)
   );

   typedef struct packed {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   resp_t sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_resp(input logic wr, input logic err, input logic [31:0] rdata);
      resp_t r;
      r.wr    = wr;
      r.err   = err;
      r.rdata = rdata;
      sb.push_back(r);
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
      cbus.cbus_m_wr    = wr;
      cbus.cbus_m_addr  = addr;
      cbus.cbus_m_wdata = wdata;
      cbus.cbus_m_req   = 1'b1;
   endtask

   // Response monitor: every pulse must match the oldest queued expectation.
   always @(negedge cbus_clk) begin
      resp_t e;
      if (cbus_rst_n) begin
         chk("one_hot_resp", 64'(cbus.cbus_s_waccept & cbus.cbus_s_rresp), 64'd0);
         if (cbus.cbus_s_waccept || cbus.cbus_s_rresp) begin
            chk("resp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("resp_kind", 64'(cbus.cbus_s_waccept), 64'(e.wr));
               chk("resp_err", 64'(cbus.cbus_s_err), 64'(e.err));
               chk("resp_rdata", 64'(cbus.cbus_s_rdata), 64'(e.rdata));
            end
         end else begin
            chk("idle_rdata_err", 64'({cbus.cbus_s_rdata, cbus.cbus_s_err}), 64'd0);
         end
      end
   end

   initial begin
      cbus.cbus_m_req   = 1'b0;
      cbus.cbus_m_wr    = 1'b0;
      cbus.cbus_m_addr  = '0;
      cbus.cbus_m_wdata = '0;
      reg_ack           = 1'b0;
      reg_rdata         = '0;
      repeat (2) @(negedge cbus_clk);

      // Reset state
      chk("rst_pulses", 64'({cbus.cbus_s_waccept, cbus.cbus_s_rresp, cbus.cbus_s_err}), 64'd0);
      chk("rst_rdata", 64'(cbus.cbus_s_rdata), 64'd0);
      chk("rst_reg_ctl", 64'({reg_req, reg_wr}), 64'd0);
      chk("rst_reg_addr", 64'(reg_addr), 64'd0);
      chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
      chk("rst_abort_cnt", 64'(abort_cnt), 64'd0);
      cbus_rst_n = 1'b1;
      @(negedge cbus_clk);

      // Read with ack in the first WAIT cycle
      issue(1'b0, 16'h0010, 32'h0);
      expect_resp(1'b0, 1'b0, 32'h1234_5678);
      @(negedge cbus_clk);
      chk("t1_reg_req_on", 64'(reg_req), 64'd1);
      chk("t1_reg_wr", 64'(reg_wr), 64'd0);
      reg_ack   = 1'b1;
      reg_rdata = 32'h1234_5678;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t1_reg_req_off", 64'(reg_req), 64'd0);
      chk("t1_rresp", 64'(cbus.cbus_s_rresp), 64'd1);
      chk("t1_waccept", 64'(cbus.cbus_s_waccept), 64'd0);
      chk("t1_rdata", 64'(cbus.cbus_s_rdata), 64'h1234_5678);
      cbus.cbus_m_req = 1'b0;
      @(negedge cbus_clk);
      chk("t1_rresp_single", 64'(cbus.cbus_s_rresp), 64'd0);
      @(negedge cbus_clk);

      // Write with five wait cycles
      issue(1'b1, 16'h0040, 32'hA5A5_A5A5);
      expect_resp(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge cbus_clk);
         chk("t2_reg_req", 64'(reg_req), 64'd1);
         chk("t2_reg_wr", 64'(reg_wr), 64'd1);
         chk("t2_reg_addr", 64'(reg_addr), 64'h0040);
         chk("t2_reg_wdata", 64'(reg_wdata), 64'hA5A5_A5A5);
         if (i == 5) reg_ack = 1'b1;
      end
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t2_waccept", 64'(cbus.cbus_s_waccept), 64'd1);
      chk("t2_rresp", 64'(cbus.cbus_s_rresp), 64'd0);
      chk("t2_err", 64'(cbus.cbus_s_err), 64'd0);
      chk("t2_reg_req_off", 64'(reg_req), 64'd0);
      cbus.cbus_m_req = 1'b0;
      @(negedge cbus_clk);
      chk("t2_waccept_single", 64'(cbus.cbus_s_waccept), 64'd0);
      @(negedge cbus_clk);

      // Local timeout on a read, then a late ack that must be ignored
      issue(1'b0, 16'h0080, 32'h0);
      expect_resp(1'b0, 1'b1, ERR_DATA);
      for (int i = 0; i < 8; i++) begin
         @(negedge cbus_clk);
         chk("t3_reg_req_hold", 64'(reg_req), 64'd1);
      end
      @(negedge cbus_clk);
      chk("t3_reg_req_off", 64'(reg_req), 64'd0);
      chk("t3_rresp", 64'(cbus.cbus_s_rresp), 64'd1);
      chk("t3_err", 64'(cbus.cbus_s_err), 64'd1);
      chk("t3_rdata", 64'(cbus.cbus_s_rdata), 64'(ERR_DATA));
      cbus.cbus_m_req = 1'b0;
      repeat (3) @(negedge cbus_clk);
      reg_ack   = 1'b1;
      reg_rdata = 32'h5555_5555;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      repeat (2) @(negedge cbus_clk);
      chk("t3_late_ack_req", 64'(reg_req), 64'd0);

      // Master abort mid-WAIT, ack arrives later
      issue(1'b0, 16'h0100, 32'h0);
      @(negedge cbus_clk);
      chk("t4_reg_req_on", 64'(reg_req), 64'd1);
      cbus.cbus_m_req = 1'b0;
      repeat (2) begin
         @(negedge cbus_clk);
         chk("t4_reg_req_held", 64'(reg_req), 64'd1);
      end
      @(negedge cbus_clk);
      reg_ack   = 1'b1;
      reg_rdata = 32'h1111_1111;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t4_no_rresp", 64'(cbus.cbus_s_rresp), 64'd0);
      chk("t4_abort_cnt_0", 64'(abort_cnt), 64'd0);
      @(negedge cbus_clk);
      chk("t4_abort_cnt_1", 64'(abort_cnt), 64'd1);
      issue(1'b0, 16'h0104, 32'h0);
      expect_resp(1'b0, 1'b0, 32'hCAFE_F00D);
      @(negedge cbus_clk);
      chk("t4_next_req", 64'(reg_req), 64'd1);
      @(negedge cbus_clk);
      reg_ack   = 1'b1;
      reg_rdata = 32'hCAFE_F00D;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t4_next_rresp", 64'(cbus.cbus_s_rresp), 64'd1);
      cbus.cbus_m_req = 1'b0;
      repeat (2) @(negedge cbus_clk);

      // m_req held high after the response
      issue(1'b1, 16'h0200, 32'h0123_4567);
      expect_resp(1'b1, 1'b0, 32'h0);
      @(negedge cbus_clk);
      reg_ack = 1'b1;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t5_waccept", 64'(cbus.cbus_s_waccept), 64'd1);
      repeat (3) begin
         @(negedge cbus_clk);
         chk("t5_no_reissue", 64'(reg_req), 64'd0);
         chk("t5_no_repulse", 64'(cbus.cbus_s_waccept), 64'd0);
      end
      cbus.cbus_m_req = 1'b0;
      @(negedge cbus_clk);
      chk("t5_low_no_req", 64'(reg_req), 64'd0);
      issue(1'b0, 16'h0204, 32'h0);
      expect_resp(1'b0, 1'b0, 32'h0BAD_F00D);
      @(negedge cbus_clk);
      chk("t5_new_req", 64'(reg_req), 64'd1);
      reg_ack   = 1'b1;
      reg_rdata = 32'h0BAD_F00D;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      chk("t5_new_rresp", 64'(cbus.cbus_s_rresp), 64'd1);
      cbus.cbus_m_req = 1'b0;
      repeat (2) @(negedge cbus_clk);

      // abort_cnt saturation from a preset start value
      force dut.abort_cnt_q = 16'hFFFE;
      repeat (2) @(negedge cbus_clk);
      release dut.abort_cnt_q;
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, 16'h0300, 32'h0);
         @(negedge cbus_clk);
         // Drop in the same cycle as the ack: still an abort.
         cbus.cbus_m_req = 1'b0;
         reg_ack         = 1'b1;
         @(negedge cbus_clk);
         reg_ack = 1'b0;
         chk("t6_no_resp", 64'({cbus.cbus_s_rresp, cbus.cbus_s_waccept}), 64'd0);
         @(negedge cbus_clk);
         chk("t6_abort_sat", 64'(abort_cnt), 64'hFFFF);
      end

      // Asynchronous reset during WAIT
      issue(1'b1, 16'h0310, 32'hFFFF_0000);
      @(negedge cbus_clk);
      chk("t7_reg_req_on", 64'(reg_req), 64'd1);
      #2 cbus_rst_n = 1'b0;
      #1;
      chk("t7_rst_reg_ctl", 64'({reg_req, reg_wr}), 64'd0);
      chk("t7_rst_reg_addr", 64'(reg_addr), 64'd0);
      chk("t7_rst_reg_wdata", 64'(reg_wdata), 64'd0);
      chk("t7_rst_abort_cnt", 64'(abort_cnt), 64'd0);
      chk("t7_rst_pulses", 64'({cbus.cbus_s_waccept, cbus.cbus_s_rresp, cbus.cbus_s_err}), 64'd0);
      chk("t7_rst_rdata", 64'(cbus.cbus_s_rdata), 64'd0);
      @(negedge cbus_clk);
      cbus.cbus_m_req = 1'b0;
      reg_ack         = 1'b1;
      @(negedge cbus_clk);
      cbus_rst_n = 1'b1;
      @(negedge cbus_clk);
      reg_ack = 1'b0;
      repeat (4) begin
         @(negedge cbus_clk);
         chk("t7_no_req_after_rst", 64'(reg_req), 64'd0);
      end
      chk("t7_abort_cnt_after", 64'(abort_cnt), 64'd0);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
